// File: rtl/qu_disp_pkg.sv
// Shared QU display-path definitions: default widths, blank nibble code, converter state encoding.
package qu_disp_pkg;

    localparam int          QU_IN_W       = 16;
    localparam int          QU_DIGITS     = 5;
    localparam logic [3:0]  QU_BLANK_CODE = 4'hF;
    localparam int          QU_CNT_W      = $clog2(QU_IN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } qu_cvt_state_t;

endpackage

// File: rtl/qu_bin2bcd_seq_if.sv
// Start/busy/done conversion handshake between the QU arithmetic core and the binary-to-BCD converter.
interface qu_bin2bcd_seq_if #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [IN_W-1:0]       bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);
endinterface

// File: rtl/qu_bin2bcd_seq_bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD digit of 5 or more, no carry out.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/qu_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter; result and done one cycle after IN_W shifts (IN_W+1 edges), start ignored while busy.
// Optional QU_LEADING_BLANK_EN replaces leading zero digits (never digit 0) with BLANK_CODE.
module qu_bin2bcd_seq
    import qu_disp_pkg::*;
#(
    parameter int IN_W   = QU_IN_W,
    parameter int DIGITS = QU_DIGITS
`ifdef QU_LEADING_BLANK_EN
    , parameter logic [3:0] BLANK_CODE = QU_BLANK_CODE
`endif
) (
    input  logic                  clk_3,
    input  logic                  clr,
    qu_bin2bcd_seq_if.slave       bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + IN_W;
    localparam int CW    = $clog2(IN_W + 1);

    qu_cvt_state_t      state;
    logic [SH_W-1:0]    sh;
    logic [SH_W-1:0]    sh_c;
    logic [BCD_W-1:0]   corr;
    logic [BCD_W-1:0]   res;
    logic [BCD_W-1:0]   bcd_q;
    logic [CW-1:0]      cnt;
    logic               busy_q;
    logic               done_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sh[IN_W + 4*g +: 4]),
            .dout (corr[4*g +: 4])
        );
    end

    assign sh_c = {corr, sh[IN_W-1:0]};

`ifdef QU_LEADING_BLANK_EN
    logic lead;
    always_comb begin
        res  = sh[SH_W-1 -: BCD_W];
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (res[4*d +: 4] == 4'd0))
                res[4*d +: 4] = BLANK_CODE;
            else
                lead = 1'b0;
        end
    end
`else
    assign res = sh[SH_W-1 -: BCD_W];
`endif

    always_ff @(posedge clk_3 or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
            sh     <= '0;
            cnt    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh     <= {{BCD_W{1'b0}}, bus.bin_in};
                        cnt    <= CW'(IN_W);
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // correct first, then shift: one full dabble step per clock
                    sh  <= sh_c << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_q  <= res;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_qu_bin2bcd_seq.sv
// Directed bench for qu_bin2bcd_seq: reset, value conversions, start-while-busy, mid-run reset, continuous start.
module tb_qu_bin2bcd_seq;

`ifdef QU_LEADING_BLANK_EN
    localparam logic [19:0] E0    = 20'hFFFF0;
    localparam logic [19:0] E1234 = 20'hF1234;
    localparam logic [19:0] E500  = 20'hFF500;
    localparam logic [19:0] E4321 = 20'hF4321;
    localparam logic [19:0] E7    = 20'hFFFF7;
    localparam logic [19:0] E8    = 20'hFFFF8;
`else
    localparam logic [19:0] E0    = 20'h00000;
    localparam logic [19:0] E1234 = 20'h01234;
    localparam logic [19:0] E500  = 20'h00500;
    localparam logic [19:0] E4321 = 20'h04321;
    localparam logic [19:0] E7    = 20'h00007;
    localparam logic [19:0] E8    = 20'h00008;
`endif

    logic clk_3 = 1'b0;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    qu_bin2bcd_seq_if #(.IN_W(16), .DIGITS(5)) bus ();

    qu_bin2bcd_seq #(.IN_W(16), .DIGITS(5)) dut (
        .clk_3 (clk_3),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk_3 = ~clk_3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // one start pulse, then watch 24 cycles; k counts rising edges after the accepting edge
    task automatic convert(input string tag, input logic [15:0] val, input logic [19:0] exp);
        int busy_n;
        int done_n;
        int lat;
        busy_n = 0;
        done_n = 0;
        lat    = -1;
        @(negedge clk_3);
        bus.start  = 1'b1;
        bus.bin_in = val;
        @(negedge clk_3);
        bus.start  = 1'b0;
        bus.bin_in = 16'($urandom);
        for (int k = 0; k < 24; k++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                lat = k;
            end
            @(negedge clk_3);
        end
        chk({tag, "_bcd"},  32'(bus.bcd_out), 32'(exp));
        chk({tag, "_lat"},  lat, 17);
        chk({tag, "_done"}, done_n, 1);
        chk({tag, "_busy"}, busy_n, 17);
    endtask

    initial begin
        int done_n;
        int busy_n;
        int lat;
        int d1;
        int d2;
        int unstable;
        logic [19:0] r1;
        logic [19:0] r2;

        clr        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(negedge clk_3);
        clr = 1'b0;
        @(negedge clk_3);
        chk("rst_bcd",  32'(bus.bcd_out), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);

        convert("zero",  16'd0,     E0);
        convert("max",   16'hFFFF,  20'h65535);
        convert("mid",   16'd1234,  E1234);
        convert("inner", 16'd10009, 20'h10009);

        // start pulses at edges 5, 16 (last shift) and 17 (DONE) must be ignored
        done_n = 0;
        busy_n = 0;
        lat    = -1;
        @(negedge clk_3);
        bus.start  = 1'b1;
        bus.bin_in = 16'd500;
        @(negedge clk_3);
        bus.start  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                lat = k;
            end
            bus.start  = (k == 4 || k == 15 || k == 16);
            bus.bin_in = 16'd999;
            @(negedge clk_3);
        end
        bus.start = 1'b0;
        chk("busy_ign_bcd",  32'(bus.bcd_out), 32'(E500));
        chk("busy_ign_done", done_n, 1);
        chk("busy_ign_lat",  lat, 17);

        // reset in the middle of a conversion
        @(negedge clk_3);
        bus.start  = 1'b1;
        bus.bin_in = 16'd4321;
        @(negedge clk_3);
        bus.start  = 1'b0;
        repeat (7) @(negedge clk_3);
        clr = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_bcd",  32'(bus.bcd_out), 32'h0);
        chk("midrst_done", 32'(bus.done), 32'h0);
        @(negedge clk_3);
        clr    = 1'b0;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) done_n++;
            @(negedge clk_3);
        end
        chk("midrst_nodone", done_n, 0);
        convert("restart", 16'd4321, E4321);

        // continuous start: back-to-back conversions, one idle cycle apart
        d1       = -1;
        d2       = -1;
        unstable = 0;
        r1       = '1;
        r2       = '1;
        @(negedge clk_3);
        bus.start  = 1'b1;
        bus.bin_in = 16'd7;
        @(negedge clk_3);
        for (int k = 0; k < 45; k++) begin
            if (bus.done && d1 < 0) begin
                d1 = k;
                r1 = bus.bcd_out;
                bus.bin_in = 16'd8;
            end else if (bus.done && d2 < 0) begin
                d2 = k;
                r2 = bus.bcd_out;
                bus.start = 1'b0;
            end else if (d1 >= 0 && d2 < 0) begin
                if (bus.bcd_out !== E7) unstable++;
            end else if (d1 < 0 && k >= 1) begin
                bus.bin_in = 16'($urandom_range(100, 60000));
            end
            @(negedge clk_3);
        end
        bus.start = 1'b0;
        chk("cont_first_lat", d1, 17);
        chk("cont_first_bcd", 32'(r1), 32'(E7));
        chk("cont_gap",       d2 - d1, 18);
        chk("cont_second_bcd", 32'(r2), 32'(E8));
        chk("cont_stable",    unstable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qu_bin2bcd_seq.md
Name: qu_bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter for the abacus quotient (QU) path.
- Takes the binary quotient from the arithmetic core and produces a 5-digit packed BCD word.
- Its output feeds the QU seven-segment scroll stage's 20-bit scroll data input, which rotates the digits across the display.
- Start/busy/done handshake; the output register holds the last result between conversions.

Parameters:
- IN_W, 16, width of the binary input.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^IN_W - 1.
- BLANK_CODE, 4'hF, nibble code the display decoder renders as a dark digit. Used only with the optional feature.

Ports:
- clk_3  input  1  block clock; all state changes on its rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  IN_W  binary quotient; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse when bcd_out has just been updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 in [3:0]. Drives the scroll stage's 20-bit data input.

Behaviour:
- Reset values, forced asynchronously while clr=1:
  - state=IDLE, busy=0, done=0, bcd_out=0, shift register=0, counter=0.
- Reset mid-conversion aborts the conversion. No done pulse is issued, and the old bcd_out is lost (it reads 0).
- State IDLE:
  - If start=1, load sh={DIGITS*4 zeros, bin_in} and cnt=IN_W, then go to SHIFT.
  - Otherwise stay in IDLE.
- State SHIFT, once per clock:
  - Every BCD nibble of sh that is >=5 gets +3 (4-bit, no carry out of the nibble).
  - The corrected register is then shifted left by 1; bit 0 takes 0.
  - cnt is decremented. When cnt reaches 1 before the decrement (the last shift), go to DONE.
  - Exactly IN_W shifts are performed.
- State DONE:
  - bcd_out <= upper DIGITS*4 bits of sh; done=1 for this cycle only.
  - Next state is IDLE.
- Outputs:
  - busy=1 in SHIFT and DONE; busy=0 in IDLE.
  - done is registered: high only on the single cycle following entry to DONE.
- Latency: start sampled at edge 0 -> bcd_out valid and done=1 after edge IN_W+1 (17 edges at default).
- Start handling:
  - start while busy=1 is ignored, with no queuing. This includes start asserted during DONE.
  - A start held high continuously restarts a conversion on the first edge in IDLE. That gives back-to-back conversions with one idle cycle between them.
  - bin_in is don't-care except on the accepted start edge; later changes do not affect the running conversion.
- Width: internal register is DIGITS*4+IN_W bits.
  - Max input 65535 gives 0x65535, so no overflow is possible at default parameters.
- bcd_out changes only in DONE or on reset. The scroll stage may sample it at any time.

Optional Feature:
- Macro QU_LEADING_BLANK_EN.
- When defined:
  - In DONE, every nibble above digit 0 that is zero is written as BLANK_CODE, scanning from the most-significant digit down and stopping at the first nonzero digit.
  - Digit 0 is never blanked.
  - Example: 1234 -> 0xF1234; 0 -> 0xFFFF0.
- When undefined: bcd_out is plain BCD with leading zeros (1234 -> 0x01234).
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package qu_disp_pkg holds:
  - IN_W/DIGITS defaults and BLANK_CODE.
  - State enum {IDLE, SHIFT, DONE}.
  - A localparam for counter width, $clog2(IN_W+1).
  - The same package is used by the scroll stage for its digit width.
- One sub-module: bcd_add3, a combinational 4-bit nibble corrector (out = in>=5 ? in+3 : in), instantiated DIGITS times by generate.
- Leading-blank logic stays inline.

Test Plan:
- Reset: clr=1 for 3 cycles, release -> bcd_out=0x00000, busy=0, done=0. Start bin_in=0 -> done after edge 17, bcd_out=0x00000 (0xFFFF0 with QU_LEADING_BLANK_EN).
- Max value: bin_in=16'hFFFF (65535) -> bcd_out=0x65535, done pulses exactly 1 cycle, busy high for 17 cycles.
- Mid value: bin_in=1234 -> bcd_out=0x01234 (0xF1234 with macro). bin_in=10009 -> 0x10009 (internal zeros not blanked).
- Start while busy: start with 500, pulse start with 999 at cycles 5 and 16 -> only one done, bcd_out=0x00500.
- Reset mid-operation: start with 4321, assert clr at cycle 8 -> busy=0, bcd_out=0, no done pulse. A restart with 4321 then yields 0x04321.
- Continuous start=1, bin_in stepping 7, 8 -> results 0x00007 then 0x00008. Done pulses 18 edges apart; bcd_out stable between pulses.
